// File: rtl/fix_trailer_gen_pkg.sv
// Shared constants for the outbound FIX trailer generator: ASCII codes,
// default sequence width and the state encoding.
package fix_trailer_gen_pkg;

    localparam int COUNTER_RANGE = 16;

    localparam logic [7:0] ASCII_SOH = 8'h01;
    localparam logic [7:0] ASCII_EQ  = 8'h3D;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_1   = 8'h31;

    // Tag "10" of the CheckSum field
    localparam logic [7:0] TAG_CHECKSUM_HI = ASCII_1;
    localparam logic [7:0] TAG_CHECKSUM_LO = ASCII_0;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_BODY = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T0   = 4'd3;
    localparam logic [3:0] ST_EQ   = 4'd4;
    localparam logic [3:0] ST_D2   = 4'd5;
    localparam logic [3:0] ST_D1   = 4'd6;
    localparam logic [3:0] ST_D0   = 4'd7;
    localparam logic [3:0] ST_SOH  = 4'd8;

endpackage

// File: rtl/fix_checksum_ascii.sv
// Converts an 8-bit checksum into three ASCII decimal digits (leading zeros kept)
// using compare/subtract steps instead of dividers.
module fix_checksum_ascii
    import fix_trailer_gen_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] d2,
    output logic [7:0] d1,
    output logic [7:0] d0
);

    logic [7:0] rem;
    logic [1:0] hund;
    logic [3:0] tens;

    always_comb begin
        rem  = value;
        hund = 2'd0;
        if (rem >= 8'd200) begin
            hund = 2'd2;
            rem  = rem - 8'd200;
        end else if (rem >= 8'd100) begin
            hund = 2'd1;
            rem  = rem - 8'd100;
        end
        tens = 4'd0;
        // At most nine tens remain after the hundreds are stripped
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        d2 = ASCII_0 + {6'd0, hund};
        d1 = ASCII_0 + {4'd0, tens};
        d0 = ASCII_0 + rem;
    end

endmodule

// File: rtl/fix_trailer_gen.sv
// Outbound FIX stage: forwards header+body bytes, stamps MsgSeqNum, accumulates
// the checksum and appends the "10=NNN<SOH>" trailer.
module fix_trailer_gen
    import fix_trailer_gen_pkg::*;
#(
    parameter int COUNTER_DEPTH = COUNTER_RANGE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               din_i,
    input  logic                     din_valid_i,
    input  logic                     din_last_i,
    output logic                     din_ready_o,
    input  logic                     seq_load_i,
    input  logic [COUNTER_DEPTH-1:0] seq_load_value_i,
    output logic [7:0]               dout_o,
    output logic                     send_message_o,
    output logic                     end_message_o,
    output logic [COUNTER_DEPTH-1:0] sequence_number_o
);

    logic [3:0]               state;
    logic [7:0]               csum;
    logic [7:0]               dig2, dig1, dig0;
    logic                     xfer;
    logic [COUNTER_DEPTH-1:0] seq_cnt, seq_pend, seq_inc;
    logic                     pend_vld;

    assign din_ready_o       = ~rst & ((state == ST_IDLE) | (state == ST_BODY));
    assign xfer              = din_valid_i & din_ready_o;
    assign sequence_number_o = seq_cnt;
    // Zero is reserved: the counter wraps from all-ones back to one
    assign seq_inc = (seq_cnt == '1) ? COUNTER_DEPTH'(1) : seq_cnt + COUNTER_DEPTH'(1);

    fix_checksum_ascii u_ascii (
        .value(csum),
        .d2   (dig2),
        .d1   (dig1),
        .d0   (dig0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dout_o         <= 8'h00;
            send_message_o <= 1'b0;
            end_message_o  <= 1'b0;
            csum           <= 8'h00;
        end else begin
            send_message_o <= 1'b0;
            end_message_o  <= 1'b0;
            case (state)
                ST_IDLE, ST_BODY: begin
                    if (xfer) begin
                        csum           <= (state == ST_IDLE) ? din_i : csum + din_i;
                        dout_o         <= din_i;
                        send_message_o <= 1'b1;
                        state          <= din_last_i ? ST_T1 : ST_BODY;
                    end
                end
                ST_T1: begin dout_o <= TAG_CHECKSUM_HI; send_message_o <= 1'b1; state <= ST_T0; end
                ST_T0: begin dout_o <= TAG_CHECKSUM_LO; send_message_o <= 1'b1; state <= ST_EQ; end
                ST_EQ: begin dout_o <= ASCII_EQ;        send_message_o <= 1'b1; state <= ST_D2; end
                ST_D2: begin dout_o <= dig2;            send_message_o <= 1'b1; state <= ST_D1; end
                ST_D1: begin dout_o <= dig1;            send_message_o <= 1'b1; state <= ST_D0; end
                ST_D0: begin dout_o <= dig0;            send_message_o <= 1'b1; state <= ST_SOH; end
                ST_SOH: begin
                    dout_o         <= ASCII_SOH;
                    send_message_o <= 1'b1;
                    end_message_o  <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A load while idle and quiet takes effect at once; otherwise it waits for
    // the message end and replaces that increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt  <= COUNTER_DEPTH'(1);
            seq_pend <= '0;
            pend_vld <= 1'b0;
        end else if ((state == ST_IDLE) && seq_load_i && !xfer) begin
            seq_cnt  <= seq_load_value_i;
            pend_vld <= 1'b0;
        end else begin
            if (end_message_o) begin
                seq_cnt  <= pend_vld ? seq_pend : seq_inc;
                pend_vld <= 1'b0;
            end
            if (seq_load_i) begin
                seq_pend <= seq_load_value_i;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Directed bench for fix_trailer_gen and its ASCII digit converter.
module tb_fix_trailer_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din_i;
    logic        din_valid_i, din_last_i, din_ready_o;
    logic        seq_load_i;
    logic [15:0] seq_load_value_i;
    logic [7:0]  dout_o;
    logic        send_message_o, end_message_o;
    logic [15:0] sequence_number_o;

    logic        rdy4, send4, end4;
    logic [7:0]  dout4;
    logic [3:0]  seq4;

    logic [7:0]  asc_in, asc_d2, asc_d1, asc_d0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fix_trailer_gen #(.COUNTER_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .din_i(din_i), .din_valid_i(din_valid_i),
        .din_last_i(din_last_i), .din_ready_o(din_ready_o), .seq_load_i(seq_load_i),
        .seq_load_value_i(seq_load_value_i), .dout_o(dout_o),
        .send_message_o(send_message_o), .end_message_o(end_message_o),
        .sequence_number_o(sequence_number_o)
    );

    fix_trailer_gen #(.COUNTER_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .din_i(din_i), .din_valid_i(din_valid_i),
        .din_last_i(din_last_i), .din_ready_o(rdy4), .seq_load_i(seq_load_i),
        .seq_load_value_i(seq_load_value_i[3:0]), .dout_o(dout4),
        .send_message_o(send4), .end_message_o(end4),
        .sequence_number_o(seq4)
    );

    fix_checksum_ascii u_asc (.value(asc_in), .d2(asc_d2), .d1(asc_d1), .d0(asc_d0));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n bytes packed MSB-first in v, optionally with one idle cycle after
    // byte gap_after and a seq_load pulse alongside byte load_at, then checks the trailer.
    task automatic run_msg(input logic [63:0] v, input int n, input int gap_after,
                           input int load_at, input logic [15:0] load_val,
                           input logic [15:0] exp_seq);
        logic [7:0] b, sum;
        logic [7:0] tr [7];
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            b   = v[8*(n-1-i) +: 8];
            sum = sum + b;
            chk1("body_ready", din_ready_o, 1'b1);
            din_i = b; din_valid_i = 1'b1; din_last_i = (i == n-1);
            seq_load_i = (i == load_at); seq_load_value_i = load_val;
            tick();
            seq_load_i = 1'b0;
            chk8("body_dout", dout_o, b);
            chk1("body_send", send_message_o, 1'b1);
            chk1("body_end", end_message_o, 1'b0);
            chk16("body_seq", sequence_number_o, exp_seq);
            if (i == gap_after) begin
                din_valid_i = 1'b0; din_last_i = 1'b0;
                tick();
                chk1("gap_send", send_message_o, 1'b0);
            end
        end
        tr[0] = 8'h31; tr[1] = 8'h30; tr[2] = 8'h3D;
        tr[3] = 8'h30 + sum / 8'd100;
        tr[4] = 8'h30 + (sum / 8'd10) % 8'd10;
        tr[5] = 8'h30 + sum % 8'd10;
        tr[6] = 8'h01;
        // Junk offered during the trailer must not be taken
        din_i = 8'hEE; din_valid_i = 1'b1; din_last_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk1("trl_ready", din_ready_o, 1'b0);
            tick();
            chk8("trl_dout", dout_o, tr[k]);
            chk1("trl_send", send_message_o, 1'b1);
            chk1("trl_end", end_message_o, k == 6);
            chk16("trl_seq", sequence_number_o, exp_seq);
        end
        din_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din_i = 8'h00; din_valid_i = 1'b0; din_last_i = 1'b0;
        seq_load_i = 1'b0; seq_load_value_i = 16'd0; asc_in = 8'd0;

        for (int v = 0; v < 256; v++) begin
            asc_in = 8'(v);
            #1;
            chk8("asc_d2", asc_d2, 8'h30 + 8'(v / 100));
            chk8("asc_d1", asc_d1, 8'h30 + 8'((v / 10) % 10));
            chk8("asc_d0", asc_d0, 8'h30 + 8'(v % 10));
        end

        tick(); tick();
        chk8("rst_dout", dout_o, 8'h00);
        chk1("rst_send", send_message_o, 1'b0);
        chk1("rst_end", end_message_o, 1'b0);
        chk1("rst_ready", din_ready_o, 1'b0);
        chk16("rst_seq", sequence_number_o, 16'd1);
        rst = 1'b0;
        tick();
        chk1("post_rst_ready", din_ready_o, 1'b1);

        run_msg(64'h4101, 2, -1, -1, 16'd0, 16'd1);          // 10=066
        run_msg(64'hFFFF01, 3, -1, -1, 16'd0, 16'd2);        // 10=255
        run_msg(64'h00, 1, -1, -1, 16'd0, 16'd3);            // 10=000
        run_msg(64'h10203001, 4, 0, -1, 16'd0, 16'd4);       // 10=097, gap after first byte
        run_msg(64'h414201, 3, -1, 1, 16'd100, 16'd5);       // 10=132, load pending
        run_msg(64'h01, 1, -1, -1, 16'd0, 16'd100);          // 10=001
        run_msg(64'h7F01, 2, -1, -1, 16'd0, 16'd101);        // 10=128

        tick();
        chk16("seq_after_msg", sequence_number_o, 16'd102);
        seq_load_i = 1'b1; seq_load_value_i = 16'd7;
        tick();
        seq_load_i = 1'b0;
        chk16("idle_load", sequence_number_o, 16'd7);
        run_msg(64'h3101, 2, -1, -1, 16'd0, 16'd7);          // 10=050

        tick();
        seq_load_i = 1'b1; seq_load_value_i = 16'd15;
        tick();
        seq_load_i = 1'b0;
        chk16("d4_load", {12'd0, seq4}, 16'd15);
        run_msg(64'h0201, 2, -1, -1, 16'd0, 16'd15);         // 10=003
        chk16("d4_seq_held", {12'd0, seq4}, 16'd15);
        tick();
        chk16("d4_wrap", {12'd0, seq4}, 16'd1);
        chk16("d16_no_wrap", sequence_number_o, 16'd16);

        // Abandon a message with reset while the tens digit is being formed
        din_i = 8'h50; din_valid_i = 1'b1; din_last_i = 1'b0;
        tick();
        chk8("abort_dout", dout_o, 8'h50);
        chk16("abort_seq", sequence_number_o, 16'd16);
        din_i = 8'h01; din_last_i = 1'b1;
        tick();
        din_valid_i = 1'b0; din_last_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk8("abort_d2", dout_o, 8'h30);
        rst = 1'b1;
        tick();
        chk8("mid_rst_dout", dout_o, 8'h00);
        chk1("mid_rst_send", send_message_o, 1'b0);
        chk1("mid_rst_end", end_message_o, 1'b0);
        chk1("mid_rst_ready", din_ready_o, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk1("after_rst_end", end_message_o, 1'b0);
            chk1("after_rst_send", send_message_o, 1'b0);
        end
        chk16("after_rst_seq", sequence_number_o, 16'd1);
        run_msg(64'h0501, 2, -1, -1, 16'd0, 16'd1);          // 10=006

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
